countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and load-value width in bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  count-down qualifier, sampled each rising edge.
REQ-005 SHALL have port load  input  1  single-cycle strobe that captures load_value and starts the countdown.
REQ-006 SHALL have port load_value  input  WIDTH  start and reload count.
REQ-007 SHALL have port auto_reload  input  1  at terminal count, 1 means reload and keep running; 0 means stop.
REQ-008 SHALL have port counter_out  output  WIDTH  current count, registered.
REQ-009 SHALL have port tc_pulse  output  1  one-cycle terminal-count strobe, registered.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port expired  output  1  high while in EXPIRED.

Function
REQ-012 SHALL implement a three-state machine: IDLE, RUN, EXPIRED.
REQ-013 SHALL, on load=1, capture load_value into counter_out and into an internal reload register on that edge, whatever the current state.
REQ-014 SHALL enter RUN on load when load_value != 0, and IDLE when load_value == 0, with tc_pulse=0 in both cases.
REQ-015 SHALL give load priority over enable and over terminal-count handling in the same cycle: the restart suppresses tc_pulse even when counter_out==1.
REQ-016 SHALL, in RUN with enable=1 and counter_out > 1, decrement counter_out by exactly 1 per edge.
REQ-017 SHALL, in RUN with enable=0, hold counter_out and state with tc_pulse=0.
REQ-018 SHALL treat RUN with enable=1 and counter_out==1 as terminal count: tc_pulse=1 on the next cycle only.
REQ-019 SHALL, at terminal count with auto_reload=0 (sampled at that edge), load counter_out=0 and enter EXPIRED.
REQ-020 SHALL, at terminal count with auto_reload=1, load counter_out from the reload register and stay in RUN, giving a period of N enabled cycles for reload value N.
REQ-021 SHALL, with reload value 1 and auto_reload=1, assert tc_pulse on every enabled cycle while counter_out stays 1.
REQ-022 SHALL never decrement below 0 or wrap: enable is ignored in IDLE and EXPIRED.
REQ-023 SHALL leave EXPIRED only on load or reset; counter_out holds 0 and expired=1 throughout.
REQ-024 SHALL drive busy=(state==RUN) and expired=(state==EXPIRED) from registered state, with no combinational path from inputs.
REQ-025 SHALL use modulo-2^WIDTH unsigned arithmetic internally, with the decrement guarded by REQ-022.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set state=IDLE, counter_out=0, reload register=0, tc_pulse=0, busy=0, expired=0.
REQ-027 SHALL give reset priority over load and enable, including mid-countdown and at terminal count; no tc_pulse follows a reset.

Structure
REQ-028 SHALL take the state encoding constants (IDLE, RUN, EXPIRED) and the default WIDTH from the shared package.
REQ-029 SHALL place the datapath (count register, reload register, decrement, zero-detect) in one sub-module, countdown_core.
REQ-030 SHALL keep the state machine and tc_pulse generation in countdown_timer.

Verification
REQ-031 Reset then load=1 with load_value=5, auto_reload=0, enable=1 held -> counter_out 5,4,3,2,1,0; tc_pulse=1 only in the cycle counter_out=0; expired=1 and busy=0 thereafter.
REQ-032 load_value=3, auto_reload=1, enable=1 for 10 cycles -> counter_out 3,2,1,3,2,1,3,... with tc_pulse once every 3 cycles and busy stays 1.
REQ-033 load_value=4, enable toggled 1,0,1,0,... -> count changes only on enable=1 cycles; tc_pulse delayed accordingly (after the 4th enabled cycle).
REQ-034 In RUN at counter_out=1, apply load=1 with load_value=7 and enable=1 together -> counter_out=7, tc_pulse=0, busy=1.
REQ-035 Assert reset with counter_out=2 mid-run, load=1 in the same cycle -> counter_out=0, IDLE, no tc_pulse; load_value=0 then gives IDLE and no tc_pulse.
REQ-036 WIDTH=4, load_value=15, auto_reload=0 -> 15 enabled cycles to EXPIRED; enable held afterwards keeps counter_out=0 with no wrap to 15.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: FSM state encoding and default width.
package countdown_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_core.sv
// Countdown datapath: count and reload registers, guarded decrement, zero/one detect.
// Control comes from countdown_timer; load outranks reload, clear and decrement.
module countdown_core
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  input  logic             reload,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
    end else if (reload) begin
      count_d = reload_q;
    end else if (clear) begin
      count_d = '0;
    end else if (dec && (count_q != '0)) begin
      // Guard keeps the count from wrapping even if dec is misused.
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count   = count_q;
  assign is_one  = (count_q == WIDTH'(1));
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer top: IDLE/RUN/EXPIRED state machine and registered terminal-count strobe.
// Load restarts from any state; reset outranks everything and suppresses tc_pulse.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc_pulse,
  output logic             busy,
  output logic             expired
);

  state_t state_q, state_d;
  logic   tc_q, tc_d;
  logic   dec, do_reload, do_clear;
  logic   is_one, is_zero;

  countdown_core #(.WIDTH(WIDTH)) u_core (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .dec        (dec),
    .reload     (do_reload),
    .clear      (do_clear),
    .count      (counter_out),
    .is_one     (is_one),
    .is_zero    (is_zero)
  );

  always_comb begin
    state_d   = state_q;
    tc_d      = 1'b0;
    dec       = 1'b0;
    do_reload = 1'b0;
    do_clear  = 1'b0;
    if (load) begin
      state_d = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          // is_zero cannot occur in RUN; treat it as terminal so the count never wraps.
          if (enable) begin
            if (is_one || is_zero) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                do_reload = 1'b1;
              end else begin
                do_clear = 1'b1;
                state_d  = ST_EXPIRED;
              end
            end else begin
              dec = 1'b1;
            end
          end
        end
        ST_IDLE, ST_EXPIRED: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign tc_pulse = tc_q;
  assign busy     = (state_q == ST_RUN);
  assign expired  = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=4).
module tb_countdown_timer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic       auto_reload;
  logic [3:0] counter_out;
  logic       tc_pulse;
  logic       busy;
  logic       expired;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.WIDTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .counter_out (counter_out),
    .tc_pulse    (tc_pulse),
    .busy        (busy),
    .expired     (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic tc,
                         input logic bsy, input logic exd);
    chk({tag, ".cnt"}, {28'd0, counter_out}, cnt);
    chk({tag, ".tc"}, {31'd0, tc_pulse}, {31'd0, tc});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
    chk({tag, ".exp"}, {31'd0, expired}, {31'd0, exd});
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = 4'd0; auto_reload = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);

    // One-shot countdown from 5 with enable held.
    reset = 1'b0; load = 1'b1; load_value = 4'd5; enable = 1'b1;
    tick();
    chk_all("os_load", 5, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      tick();
      chk_all("os_dec", v, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk_all("os_tc", 0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("os_hold", 0, 1'b0, 1'b0, 1'b1);

    // Auto-reload with period 3.
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b1;
    tick();
    chk_all("ar_load", 3, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("ar_run", 3 - (k % 3), (k % 3) == 0, 1'b1, 1'b0);
    end
    tick();
    chk_all("ar_at1", 1, 1'b0, 1'b1, 1'b0);

    // Load at counter_out==1 with enable: restart wins, no tc.
    load = 1'b1; load_value = 4'd7;
    tick();
    chk_all("ld_pri", 7, 1'b0, 1'b1, 1'b0);

    // Toggled enable from 4.
    load_value = 4'd4; auto_reload = 1'b0;
    tick();
    chk_all("tg_load", 4, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      enable = (j % 2) == 1;
      tick();
      chk_all("tg_run", 4 - (j + 1) / 2, j == 7, j < 7, j >= 7);
    end

    // Reset mid-run beats a simultaneous load.
    enable = 1'b1; load = 1'b1; load_value = 4'd4;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk_all("rs_mid_pre", 2, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; load = 1'b1; load_value = 4'd9;
    tick();
    chk_all("rs_mid", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; load_value = 4'd0;
    tick();
    chk_all("ld_zero", 0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    chk_all("idle_en", 0, 1'b0, 1'b0, 1'b0);

    // Reset exactly at terminal count suppresses tc.
    load = 1'b1; load_value = 4'd1;
    tick();
    chk_all("rs_tc_pre", 1, 1'b0, 1'b1, 1'b0);
    load = 1'b0; reset = 1'b1;
    tick();
    chk_all("rs_tc", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("rs_tc_post", 0, 1'b0, 1'b0, 1'b0);

    // Reload value 1 with auto_reload: tc every enabled cycle.
    load = 1'b1; load_value = 4'd1; auto_reload = 1'b1;
    tick();
    chk_all("r1_load", 1, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    tick();
    chk_all("r1_tc_a", 1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("r1_tc_b", 1, 1'b1, 1'b1, 1'b0);
    enable = 1'b0;
    tick();
    chk_all("r1_hold", 1, 1'b0, 1'b1, 1'b0);

    // Full-range countdown from 15, then no wrap while expired.
    enable = 1'b1; load = 1'b1; load_value = 4'd15; auto_reload = 1'b0;
    tick();
    chk_all("max_load", 15, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    for (int v = 14; v >= 1; v--) begin
      tick();
      chk_all("max_dec", v, 1'b0, 1'b1, 1'b0);
    end
    tick();
    chk_all("max_tc", 0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_all("max_nowrap", 0, 1'b0, 1'b0, 1'b1);
    end

    // Leaving EXPIRED via load.
    load = 1'b1; load_value = 4'd2;
    tick();
    chk_all("exp_exit", 2, 1'b0, 1'b1, 1'b0);
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
